// File: rtl/oki_adpcm_multi.sv
// Multi-chip OKIM6295 sound subsystem: shared fractional clock enable, per-chip ROM
// banking, round-robin arbitration onto one ROM read port and a saturating mixer.

// Minimal PCM voice exposing the jt6295 port set; stands in for jt6295 in this block.
// CPU byte din[7:6]: 11/10/01 load rom_addr[17:12]/[11:6]/[5:0] from din[5:0]; 00 sets play=din[0].
module oki_adpcm_voice (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               wr,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic [17:0]        rom_addr,
    input  logic [7:0]         rom_data,
    input  logic               rom_ok,
    output logic signed [13:0] sound,
    output logic               sample
);
    logic play;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            play     <= 1'b0;
            sound    <= '0;
            sample   <= 1'b0;
        end else begin
            sample <= 1'b0;
            if (wr) begin
                case (din[7:6])
                    2'b11:   rom_addr[17:12] <= din[5:0];
                    2'b10:   rom_addr[11:6]  <= din[5:0];
                    2'b01:   rom_addr[5:0]   <= din[5:0];
                    default: play            <= din[0];
                endcase
            end else if (play && cen && rom_ok) begin
                // stalls here whenever the ROM byte for rom_addr has not arrived
                sound    <= {rom_data, rom_data[5:0]};
                sample   <= 1'b1;
                rom_addr <= rom_addr + 18'd1;
            end
        end
    end

    assign dout = {7'd0, play};
endmodule

module oki_adpcm_multi #(
    parameter int unsigned   NUM_CHIPS      = 2,
    parameter logic [15:0]   CEN_INC        = 16'h10E5,
    parameter int unsigned   ROM_ADDR_WIDTH = 22,
    parameter int unsigned   OUT_WIDTH      = 16,
    localparam int unsigned  CHIP_W         = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_CHIPS-1:0]          io_cpu_wr,
    input  logic [7:0]                    io_cpu_din,
    output logic [8*NUM_CHIPS-1:0]        io_cpu_dout,
    input  logic                          io_bank_wr,
    input  logic [CHIP_W-1:0]             io_bank_chip,
    input  logic [1:0]                    io_bank_region,
    input  logic [ROM_ADDR_WIDTH-17:0]    io_bank_din,
    output logic                          io_rom_rd,
    output logic [ROM_ADDR_WIDTH-1:0]     io_rom_addr,
    input  logic [7:0]                    io_rom_dout,
    input  logic                          io_rom_valid,
    output logic                          io_audio_valid,
    output logic signed [OUT_WIDTH-1:0]   io_audio_bits
);
    localparam int unsigned AW = ROM_ADDR_WIDTH;
    localparam int unsigned BW = ROM_ADDR_WIDTH - 16;
    localparam int unsigned SW = ((OUT_WIDTH > 16) ? OUT_WIDTH : 16) + 1;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((longint'(1) <<< (OUT_WIDTH - 1)) - longint'(1));
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

    logic [15:0]       acc;
    logic [16:0]       acc_sum;
    logic              cen;
    logic              core_rst;
    logic [BW-1:0]     bank [NUM_CHIPS][4];
    logic [17:0]       core_addr [NUM_CHIPS];
    logic signed [13:0] core_sound [NUM_CHIPS];
    logic [NUM_CHIPS-1:0] core_sample;
    logic [AW-1:0]     mapped [NUM_CHIPS];
    logic [AW-1:0]     served_addr [NUM_CHIPS];
    logic [7:0]        served_data [NUM_CHIPS];
    logic [NUM_CHIPS-1:0] served_ok;
    logic [NUM_CHIPS-1:0] rom_ok;
    logic [NUM_CHIPS-1:0] pending;
    arb_state_t        state, state_nxt;
    logic [CHIP_W-1:0] rr_ptr, grant, pick;
    logic              pick_ok;
    logic signed [13:0] held [NUM_CHIPS];
    logic signed [13:0] held_nxt [NUM_CHIPS];
    logic signed [SW-1:0] mix_sum, mix_sat;

    // Fractional clock enable plus a registered core reset so cores leave reset synchronously
    assign acc_sum = {1'b0, acc} + {1'b0, CEN_INC};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            cen      <= 1'b0;
            core_rst <= 1'b1;
        end else begin
            acc      <= acc_sum[15:0];
            cen      <= acc_sum[16];
            core_rst <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < int'(NUM_CHIPS); c++)
                for (int r = 0; r < 4; r++)
                    bank[c][r] <= BW'(r);
        end else if (io_bank_wr && (32'(io_bank_chip) < NUM_CHIPS)) begin
            bank[io_bank_chip][io_bank_region] <= io_bank_din;
        end
    end

    for (genvar c = 0; c < int'(NUM_CHIPS); c++) begin : g_chip
        assign mapped[c] = {bank[c][core_addr[c][17:16]], core_addr[c][15:0]};
        assign rom_ok[c] = served_ok[c] && (served_addr[c] == mapped[c]);

        oki_adpcm_voice u_voice (
            .clk      (clock),
            .rst      (core_rst),
            .cen      (cen),
            .wr       (io_cpu_wr[c]),
            .din      (io_cpu_din),
            .dout     (io_cpu_dout[8*c +: 8]),
            .rom_addr (core_addr[c]),
            .rom_data (served_data[c]),
            .rom_ok   (rom_ok[c]),
            .sound    (core_sound[c]),
            .sample   (core_sample[c])
        );
    end

    assign pending = ~rom_ok;

    // First pending chip at or after the round-robin pointer
    always_comb begin
        int unsigned idx;
        idx     = 0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int k = int'(NUM_CHIPS) - 1; k >= 0; k--) begin
            idx = (32'(rr_ptr) + 32'(k)) % NUM_CHIPS;
            if (pending[CHIP_W'(idx)]) begin
                pick    = CHIP_W'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ARB_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (pick_ok)      state_nxt = ARB_WAIT;
            ARB_WAIT: if (io_rom_valid) state_nxt = ARB_IDLE;
            default:                    state_nxt = ARB_IDLE;
        endcase
    end

    // Read port and per-chip slots; the latched address is what gets stored, so a
    // bank or core address change during WAIT just causes a re-request afterwards
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            io_rom_rd   <= 1'b0;
            io_rom_addr <= '0;
            grant       <= '0;
            rr_ptr      <= '0;
            served_ok   <= '0;
            for (int c = 0; c < int'(NUM_CHIPS); c++) begin
                served_addr[c] <= '0;
                served_data[c] <= '0;
            end
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_ok) begin
                        io_rom_rd   <= 1'b1;
                        io_rom_addr <= mapped[pick];
                        grant       <= pick;
                    end
                end
                ARB_WAIT: begin
                    if (io_rom_valid) begin
                        io_rom_rd          <= 1'b0;
                        served_addr[grant] <= io_rom_addr;
                        served_data[grant] <= io_rom_dout;
                        served_ok[grant]   <= 1'b1;
                        rr_ptr <= (32'(grant) == NUM_CHIPS - 1) ? '0 : CHIP_W'(32'(grant) + 1);
                    end
                end
                default: io_rom_rd <= 1'b0;
            endcase
        end
    end

    // Mixer sums the freshly updated held samples so output lags a core sample by one clock
    always_comb begin
        held_nxt = held;
        mix_sum  = '0;
        for (int c = 0; c < int'(NUM_CHIPS); c++) begin
            if (core_sample[c]) held_nxt[c] = core_sound[c];
            mix_sum = mix_sum + SW'(held_nxt[c]);
        end
        mix_sat = (mix_sum > SAT_MAX) ? SAT_MAX : ((mix_sum < SAT_MIN) ? SAT_MIN : mix_sum);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < int'(NUM_CHIPS); c++) held[c] <= '0;
            io_audio_valid <= 1'b0;
            io_audio_bits  <= '0;
        end else begin
            held           <= held_nxt;
            io_audio_valid <= |core_sample;
            if (|core_sample) io_audio_bits <= OUT_WIDTH'(mix_sat);
        end
    end
endmodule

// File: tb/tb_oki_adpcm_multi.sv
// Bench for oki_adpcm_multi: banking table, arbitration order, stall, mixer saturation, reset.
module tb_oki_adpcm_multi;
    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, rst_b_n;
    logic [1:0]  cpu_wr, cpu_wr_b;
    logic [7:0]  cpu_din, cpu_din_b;
    logic [15:0] cpu_dout, cpu_dout_b;
    logic        bank_wr;
    logic [0:0]  bank_chip;
    logic [1:0]  bank_region;
    logic [5:0]  bank_din;
    logic        rom_rd, rom_rd_b, rom_valid, rom_valid_b;
    logic [21:0] rom_addr, rom_addr_b;
    logic [7:0]  rom_dout, rom_dout_b;
    logic        audio_valid, audio_valid_b;
    logic [15:0] audio_bits;
    logic [13:0] audio_bits_b;
    logic        rom_hold;
    logic [7:0]  rom_b_data;
    logic [21:0] rom_log[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    oki_adpcm_multi dut (
        .clock(clock), .reset_n(reset_n), .io_cpu_wr(cpu_wr), .io_cpu_din(cpu_din),
        .io_cpu_dout(cpu_dout), .io_bank_wr(bank_wr), .io_bank_chip(bank_chip),
        .io_bank_region(bank_region), .io_bank_din(bank_din), .io_rom_rd(rom_rd),
        .io_rom_addr(rom_addr), .io_rom_dout(rom_dout), .io_rom_valid(rom_valid),
        .io_audio_valid(audio_valid), .io_audio_bits(audio_bits)
    );

    oki_adpcm_multi #(.NUM_CHIPS(2), .CEN_INC(16'h8000), .ROM_ADDR_WIDTH(22), .OUT_WIDTH(14)) dut_b (
        .clock(clock), .reset_n(rst_b_n), .io_cpu_wr(cpu_wr_b), .io_cpu_din(cpu_din_b),
        .io_cpu_dout(cpu_dout_b), .io_bank_wr(1'b0), .io_bank_chip(1'b0),
        .io_bank_region(2'b00), .io_bank_din(6'h00), .io_rom_rd(rom_rd_b),
        .io_rom_addr(rom_addr_b), .io_rom_dout(rom_dout_b), .io_rom_valid(rom_valid_b),
        .io_audio_valid(audio_valid_b), .io_audio_bits(audio_bits_b)
    );

    typedef struct {
        logic [1:0]  region;
        logic [5:0]  bank;
        logic [17:0] a;
        logic [21:0] exp;
    } map_vec_t;

    function automatic logic [7:0] rom_fn(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [21:0] log_at(input int i);
        if (i < 0 || i >= rom_log.size()) return 'x;
        return rom_log[i];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ROM model for the main instance: two-cycle latency, optional hold-off
    initial begin
        int cnt;
        cnt = 0; rom_valid = 1'b0; rom_dout = '0;
        forever begin
            @(negedge clock);
            rom_valid = 1'b0;
            if (!rom_rd || rom_hold) cnt = 0;
            else begin
                cnt++;
                if (cnt == 2) begin
                    rom_valid = 1'b1;
                    rom_dout  = rom_fn(rom_addr);
                    rom_log.push_back(rom_addr);
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0; rom_valid_b = 1'b0; rom_dout_b = '0;
        forever begin
            @(negedge clock);
            rom_valid_b = 1'b0;
            if (!rom_rd_b) cnt = 0;
            else begin
                cnt++;
                if (cnt == 2) begin
                    rom_valid_b = 1'b1;
                    rom_dout_b  = rom_b_data;
                    cnt = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cpu_write(input logic [1:0] mask, input logic [7:0] d);
        @(negedge clock); cpu_wr = mask; cpu_din = d;
        @(negedge clock); cpu_wr = '0;
    endtask

    task automatic cpu_write_b(input logic [1:0] mask, input logic [7:0] d);
        @(negedge clock); cpu_wr_b = mask; cpu_din_b = d;
        @(negedge clock); cpu_wr_b = '0;
    endtask

    task automatic set_core_addr(input logic [1:0] mask, input logic [17:0] a);
        cpu_write(mask, {2'b11, a[17:12]});
        cpu_write(mask, {2'b10, a[11:6]});
        cpu_write(mask, {2'b01, a[5:0]});
    endtask

    task automatic bank_write(input logic c, input logic [1:0] r, input logic [5:0] v);
        @(negedge clock); bank_wr = 1'b1; bank_chip = c; bank_region = r; bank_din = v;
        @(negedge clock); bank_wr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int quiet, t;
        quiet = 0; t = 0;
        while (quiet < 4 && t < 400) begin
            @(negedge clock);
            t++;
            quiet = rom_rd ? 0 : quiet + 1;
        end
        if (quiet < 4) begin
            n_checks++;
            $display("FAIL %s: arbiter busy after %0d cycles", name, t);
        end
    endtask

    task automatic wait_high(input string name, input int which, input int limit, output logic seen);
        seen = 1'b0;
        for (int t = 0; t < limit && !seen; t++) begin
            @(negedge clock);
            case (which)
                0:       seen = rom_rd;
                1:       seen = audio_valid;
                default: seen = audio_valid_b;
            endcase
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s: event not seen within %0d cycles", name, limit);
        end
    endtask

    initial begin
        map_vec_t vecs[5];
        logic     seen;
        int       bad, cen_cnt;

        vecs[0] = '{2'd2, 6'h02, 18'h21234, 22'h021234};
        vecs[1] = '{2'd2, 6'h2A, 18'h21234, 22'h2A1234};
        vecs[2] = '{2'd3, 6'h3F, 18'h3FFFF, 22'h3FFFFF};
        vecs[3] = '{2'd0, 6'h01, 18'h00ABC, 22'h010ABC};
        vecs[4] = '{2'd1, 6'h10, 18'h10000, 22'h100000};

        reset_n = 1'b0; rst_b_n = 1'b0; rom_hold = 1'b0; rom_b_data = 8'h7F;
        cpu_wr = '0; cpu_din = '0; cpu_wr_b = '0; cpu_din_b = '0;
        bank_wr = 1'b0; bank_chip = '0; bank_region = '0; bank_din = '0;
        tick(3);
        check("rst_rom_rd", rom_rd, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_audio_valid", audio_valid, 0);
        check("rst_audio_bits", audio_bits, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        @(negedge clock); reset_n = 1'b1;
        wait_idle("boot");

        bank_write(1'b1, 2'd0, 6'h05);
        wait_idle("bank1");
        check("bank_chip1", log_at(rom_log.size() - 1), 22'h050000);

        // Both chips go pending on the same edge with the pointer at chip 0
        rom_log.delete();
        cpu_write(2'b11, 8'h51);
        wait_idle("rr");
        check("rr_count", rom_log.size(), 2);
        check("rr_first", log_at(0), 22'h000011);
        check("rr_second", log_at(1), 22'h050011);

        for (int i = 0; i < 5; i++) begin
            bank_write(1'b0, vecs[i].region, vecs[i].bank);
            set_core_addr(2'b01, vecs[i].a);
            wait_idle($sformatf("map%0d", i));
            check($sformatf("map%0d", i), log_at(rom_log.size() - 1), vecs[i].exp);
        end

        // Stall: ROM withholds data for 50 clocks while chip 0 wants to play
        rom_hold = 1'b1;
        cpu_write(2'b01, 8'h45);
        wait_high("stall_rd", 0, 20, seen);
        check("stall_addr", rom_addr, 22'h100005);
        cpu_write(2'b01, 8'h01);
        bad = 0;
        repeat (50) begin
            @(negedge clock);
            if (!rom_rd || rom_addr !== 22'h100005 || audio_valid) bad++;
        end
        check("stall_stable", bad, 0);
        check("status_play", cpu_dout, 16'h0001);
        rom_hold = 1'b0;
        wait_high("play_sample", 1, 200, seen);
        if (seen) check("mix_single", audio_bits, 16'hE820);
        cpu_write(2'b01, 8'h00);

        // Reset while a read is outstanding
        rom_hold = 1'b1;
        cpu_write(2'b01, 8'h4A);
        wait_high("midrst_rd", 0, 20, seen);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_rom_rd", rom_rd, 0);
        check("midrst_rom_addr", rom_addr, 0);
        check("midrst_audio_bits", audio_bits, 0);
        tick(3);
        rom_hold = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        wait_idle("reboot");
        check("midrst_cpu_dout", cpu_dout, 0);
        rom_log.delete();
        set_core_addr(2'b01, 18'h21234);
        wait_idle("bank_identity");
        check("bank_identity", log_at(rom_log.size() - 1), 22'h021234);

        // Second instance: half-rate enable and 14-bit saturation
        @(negedge clock); rst_b_n = 1'b1;
        cen_cnt = 0;
        repeat (100) begin
            @(negedge clock);
            if (dut_b.cen) cen_cnt++;
        end
        check("cen_count", cen_cnt, 50);
        tick(5);
        cpu_write_b(2'b11, 8'h01);
        wait_high("sat_pos_wait", 2, 100, seen);
        if (seen) begin
            check("sat_pos", audio_bits_b, 14'h1FFF);
            @(negedge clock);
            check("sat_single_pulse", audio_valid_b, 0);
        end
        cpu_write_b(2'b11, 8'h00);
        rom_b_data = 8'h80;
        cpu_write_b(2'b11, 8'h60);
        tick(40);
        cpu_write_b(2'b11, 8'h01);
        wait_high("sat_neg_wait", 2, 100, seen);
        if (seen) check("sat_neg", audio_bits_b, 14'h2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
